// File: rtl/mem_stage_lsu_if.sv
// ============================================================================
//  Module   : mem_stage_lsu_if
//  Purpose  : Data-memory req/ack port between the MEM-stage LSU and memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ack, dmem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
//  Module   : mem_stage_lsu
//  Purpose  : MEM-stage load/store unit: stalls the pipeline across a
//             multi-cycle req/ack access, formats loads, flags faults.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata_in,
    input  logic [2:0]            mem_funct3,
    mem_stage_lsu_if.master       dmem,
    output logic [31:0]           mem_read_data,
    output logic                  mem_stall,
    output logic                  mem_misalign,
    output logic                  mem_bus_err
);

    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_req;
    logic                 r_we;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [3:0]           r_wstrb;
    logic [31:0]          r_read_data;
    logic                 r_misalign;
    logic                 r_bus_err;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_funct3;
    logic [1:0]           r_lane;
    logic                 r_is_load;

    logic                 w_start;
    logic                 w_legal;
    logic                 w_aligned;
    logic                 w_go;
    logic                 w_fault;
    logic                 w_timeout;
    logic [31:0]          w_st_wdata;
    logic [3:0]           w_st_wstrb;
    logic [31:0]          w_rshift;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_ld_data;

    assign w_start   = mem_valid & (mem_read | mem_write);
    assign w_go      = w_start & w_legal & w_aligned;
    assign w_fault   = w_start & ~(w_legal & w_aligned);
    assign w_timeout = (r_cnt == c_cnt_last);

    always_comb begin
        w_legal = 1'b0;
        if (mem_read) begin
            case (mem_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                default:                                w_legal = 1'b0;
            endcase
        end else if (mem_write) begin
            case (mem_funct3)
                3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                default:                w_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (mem_funct3[1:0])
            2'b01:   w_aligned = ~mem_addr[0];
            2'b10:   w_aligned = (mem_addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    // Store data is replicated across lanes; the strobe selects the live one.
    always_comb begin
        case (mem_funct3[1:0])
            2'b00: begin
                w_st_wdata = {4{mem_wdata_in[7:0]}};
                w_st_wstrb = 4'b0001 << mem_addr[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{mem_wdata_in[15:0]}};
                w_st_wstrb = 4'b0011 << {mem_addr[1], 1'b0};
            end
            default: begin
                w_st_wdata = mem_wdata_in;
                w_st_wstrb = 4'b1111;
            end
        endcase
    end

    assign w_rshift = dmem.dmem_rdata >> {r_lane, 3'b000};
    assign w_byte   = w_rshift[7:0];
    assign w_half   = r_lane[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

    always_comb begin
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_data = {24'h0, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_data = {16'h0, w_half};
            default: w_ld_data = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Stall is raised in IDLE only for an access that will really go to memory.
    always_comb begin
        w_next    = r_state;
        mem_stall = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    mem_stall = 1'b1;
                    w_next    = BUSY;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (dmem.dmem_ack || w_timeout) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_wstrb     <= 4'h0;
            r_read_data <= 32'h0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_cnt       <= '0;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_is_load   <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_req     <= 1'b1;
                        r_we      <= mem_write;
                        r_addr    <= {mem_addr[31:2], 2'b00};
                        r_wdata   <= w_st_wdata;
                        r_wstrb   <= mem_write ? w_st_wstrb : 4'h0;
                        r_cnt     <= '0;
                        r_funct3  <= mem_funct3;
                        r_lane    <= mem_addr[1:0];
                        r_is_load <= mem_read;
                    end else if (w_fault) begin
                        r_misalign  <= 1'b1;
                        r_read_data <= 32'h0;
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ack) begin
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_wstrb <= 4'h0;
                        if (r_is_load) r_read_data <= w_ld_data;
                    end else if (w_timeout) begin
                        r_req       <= 1'b0;
                        r_we        <= 1'b0;
                        r_wstrb     <= 4'h0;
                        r_read_data <= 32'h0;
                        r_bus_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_wstrb = r_wstrb;
    assign mem_read_data   = r_read_data;
    assign mem_misalign    = r_misalign;
    assign mem_bus_err     = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
//  Module   : tb_mem_stage_lsu
//  Purpose  : Directed self-checking bench for mem_stage_lsu.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata_in;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_read_data;
    logic        mem_stall;
    logic        mem_misalign;
    logic        mem_bus_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_req;

    mem_stage_lsu_if dmem ();

    mem_stage_lsu #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata_in (mem_wdata_in),
        .mem_funct3   (mem_funct3),
        .dmem         (dmem),
        .mem_read_data(mem_read_data),
        .mem_stall    (mem_stall),
        .mem_misalign (mem_misalign),
        .mem_bus_err  (mem_bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] f3);
        mem_valid    = 1'b1;
        mem_read     = rd;
        mem_write    = wr;
        mem_addr     = a;
        mem_wdata_in = wd;
        mem_funct3   = f3;
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Walks n_busy BUSY cycles, acks in the last, and returns in the DONE cycle.
    task automatic busy_then_ack(input int n_busy, input logic [31:0] rdata,
                                 input logic [31:0] e_addr, input logic e_we,
                                 input logic [31:0] e_wdata, input logic [3:0] e_wstrb);
        for (int i = 1; i <= n_busy; i++) begin
            tick();
            chk("busy_stall", {31'h0, mem_stall}, 32'h1);
            chk("busy_req", {31'h0, dmem.dmem_req}, 32'h1);
            if (i == 1) begin
                chk("busy_addr", dmem.dmem_addr, e_addr);
                chk("busy_we", {31'h0, dmem.dmem_we}, {31'h0, e_we});
                chk("busy_wstrb", {28'h0, dmem.dmem_wstrb}, {28'h0, e_wstrb});
                if (e_we) chk("busy_wdata", dmem.dmem_wdata, e_wdata);
            end
            if (i == n_busy) begin
                dmem.dmem_ack   = 1'b1;
                dmem.dmem_rdata = rdata;
            end
        end
        tick();
        dmem.dmem_ack = 1'b0;
        idle_inputs();
        chk("done_stall", {31'h0, mem_stall}, 32'h0);
        chk("done_req", {31'h0, dmem.dmem_req}, 32'h0);
        chk("done_wstrb", {28'h0, dmem.dmem_wstrb}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        mem_addr = 32'h0; mem_wdata_in = 32'h0; mem_funct3 = 3'b000;
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 32'h0;
        tick(); tick();
        chk("rst_req", {31'h0, dmem.dmem_req}, 32'h0);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        chk("rst_rdata", mem_read_data, 32'h0);
        chk("rst_addr", dmem.dmem_addr, 32'h0);
        chk("rst_faults", {30'h0, mem_misalign, mem_bus_err}, 32'h0);
        rst = 1'b0;

        // LW 0x100, ack in third BUSY cycle: 4 stall cycles total
        tick();
        start_op(1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
        chk("lw_idle_stall", {31'h0, mem_stall}, 32'h1);
        busy_then_ack(3, 32'hDEADBEEF, 32'h100, 1'b0, 32'h0, 4'h0);
        chk("lw_data", mem_read_data, 32'hDEADBEEF);
        chk("lw_buserr", {31'h0, mem_bus_err}, 32'h0);
        tick();
        chk("lw_hold", mem_read_data, 32'hDEADBEEF);

        // LB / LBU at 0x1001, minimum-latency ack
        start_op(1'b1, 1'b0, 32'h1001, 32'h0, 3'b000);
        busy_then_ack(1, 32'h123480FF, 32'h1000, 1'b0, 32'h0, 4'h0);
        chk("lb_data", mem_read_data, 32'hFFFFFF80);
        tick();
        start_op(1'b1, 1'b0, 32'h1001, 32'h0, 3'b100);
        busy_then_ack(1, 32'h123480FF, 32'h1000, 1'b0, 32'h0, 4'h0);
        chk("lbu_data", mem_read_data, 32'h00000080);
        tick();

        // LH / LHU upper half
        start_op(1'b1, 1'b0, 32'h1802, 32'h0, 3'b001);
        busy_then_ack(2, 32'h9ABC1234, 32'h1800, 1'b0, 32'h0, 4'h0);
        chk("lh_data", mem_read_data, 32'hFFFF9ABC);
        tick();
        start_op(1'b1, 1'b0, 32'h1802, 32'h0, 3'b101);
        busy_then_ack(1, 32'h9ABC1234, 32'h1800, 1'b0, 32'h0, 4'h0);
        chk("lhu_data", mem_read_data, 32'h00009ABC);
        tick();

        // Stores leave mem_read_data untouched
        start_op(1'b0, 1'b1, 32'h2002, 32'h0000ABCD, 3'b001);
        busy_then_ack(2, 32'h55555555, 32'h2000, 1'b1, 32'hABCDABCD, 4'b1100);
        chk("sh_rdata_kept", mem_read_data, 32'h00009ABC);
        chk("sh_we_clr", {31'h0, dmem.dmem_we}, 32'h0);
        tick();
        start_op(1'b0, 1'b1, 32'h2003, 32'h12345678, 3'b000);
        busy_then_ack(1, 32'h0, 32'h2000, 1'b1, 32'h78787878, 4'b1000);
        tick();
        start_op(1'b0, 1'b1, 32'h2004, 32'hA5A5F00F, 3'b010);
        busy_then_ack(1, 32'h0, 32'h2004, 1'b1, 32'hA5A5F00F, 4'b1111);
        chk("sw_rdata_kept", mem_read_data, 32'h00009ABC);
        tick();

        // Misaligned LW: no stall, no request, one-cycle fault, data zeroed
        start_op(1'b1, 1'b0, 32'h3002, 32'h0, 3'b010);
        chk("mis_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        idle_inputs();
        chk("mis_pulse", {31'h0, mem_misalign}, 32'h1);
        chk("mis_req", {31'h0, dmem.dmem_req}, 32'h0);
        chk("mis_rdata", mem_read_data, 32'h0);
        tick();
        chk("mis_pulse_end", {31'h0, mem_misalign}, 32'h0);
        chk("mis_req2", {31'h0, dmem.dmem_req}, 32'h0);

        // Illegal load funct3 011 at an aligned address
        start_op(1'b1, 1'b0, 32'h3000, 32'h0, 3'b011);
        chk("ill_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        idle_inputs();
        chk("ill_pulse", {31'h0, mem_misalign}, 32'h1);
        chk("ill_req", {31'h0, dmem.dmem_req}, 32'h0);
        tick();
        chk("ill_pulse_end", {31'h0, mem_misalign}, 32'h0);

        // Ack on the 16th BUSY cycle wins over the timeout
        start_op(1'b1, 1'b0, 32'h400, 32'h0, 3'b010);
        busy_then_ack(16, 32'hCAFEF00D, 32'h400, 1'b0, 32'h0, 4'h0);
        chk("late_ack_err", {31'h0, mem_bus_err}, 32'h0);
        chk("late_ack_data", mem_read_data, 32'hCAFEF00D);
        tick();

        // No ack: request held 16 cycles, then bus error in DONE
        start_op(1'b1, 1'b0, 32'h500, 32'h0, 3'b010);
        n_req = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dmem.dmem_req !== 1'b1) break;
            n_req++;
        end
        idle_inputs();
        chk("to_req_cycles", n_req, 32'd16);
        chk("to_buserr", {31'h0, mem_bus_err}, 32'h1);
        chk("to_rdata", mem_read_data, 32'h0);
        chk("to_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        chk("to_buserr_end", {31'h0, mem_bus_err}, 32'h0);

        // Reset mid-BUSY drops the request at once; a late ack is ignored
        start_op(1'b1, 1'b0, 32'h600, 32'h0, 3'b010);
        tick(); tick();
        chk("rb_req", {31'h0, dmem.dmem_req}, 32'h1);
        #2;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rb_req_drop", {31'h0, dmem.dmem_req}, 32'h0);
        chk("rb_addr", dmem.dmem_addr, 32'h0);
        chk("rb_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        rst = 1'b0;
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = 32'hFFFFFFFF;
        tick();
        dmem.dmem_ack = 1'b0;
        chk("rb_ack_req", {31'h0, dmem.dmem_req}, 32'h0);
        chk("rb_ack_rdata", mem_read_data, 32'h0);
        chk("rb_ack_err", {31'h0, mem_bus_err}, 32'h0);
        chk("rb_ack_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        chk("rb_idle_req", {31'h0, dmem.dmem_req}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit between the EX/MEM register and the MEM/WB register. It takes address, store data and funct3 from EX/MEM and runs a multi-cycle req/ack transaction on the data-memory port. It formats load data (byte/half/word, sign or zero extension) into mem_read_data, which MEM/WB captures. It stalls the pipeline for the whole transaction and flags misaligned or illegal accesses and bus timeouts.

Parameters:
TIMEOUT, 16, number of BUSY cycles without dmem_ack before the access is aborted with a bus error (must be >= 1).

Ports:
clk  in  1  pipeline clock, rising edge.
rst  in  1  asynchronous, active-high reset.
mem_valid  in  1  EX/MEM slot holds a valid instruction.
mem_read  in  1  instruction is a load.
mem_write  in  1  instruction is a store (never asserted together with mem_read).
mem_addr  in  32  effective address (EX/MEM ALU result).
mem_wdata_in  in  32  store data (rs2).
mem_funct3  in  3  instr[14:12].
dmem_req  out  1  data-memory request, registered.
dmem_we  out  1  write enable, registered.
dmem_addr  out  32  word address {mem_addr[31:2],2'b00}, registered.
dmem_wdata  out  32  lane-replicated store data, registered.
dmem_wstrb  out  4  byte strobes, registered; 0 on loads.
dmem_ack  in  1  one-cycle completion pulse; rdata valid with it.
dmem_rdata  in  32  read word.
mem_read_data  out  32  formatted load result to MEM/WB, registered.
mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert a bubble into MEM/WB.
mem_misalign  out  1  one-cycle fault pulse for misaligned or illegal access.
mem_bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, any state): state=IDLE; dmem_req, dmem_we, dmem_wstrb, mem_misalign, mem_bus_err = 0; dmem_addr, dmem_wdata, mem_read_data = 0; timeout counter = 0. Any in-flight request is dropped immediately. A late ack after reset is ignored.
- start = mem_valid & (mem_read | mem_write).
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, start, legal and aligned:
  - mem_stall=1 (combinational).
  - Next edge: go to BUSY and load the dmem_* registers, so dmem_req=1 from the first BUSY cycle. Counter cleared.
- IDLE, start, illegal or misaligned:
  - No memory access; mem_stall=0.
  - Next edge: mem_misalign=1 for one cycle and mem_read_data=0. Stay IDLE.
- IDLE, no start: mem_stall=0; mem_read_data holds its value.
- BUSY: mem_stall=1; dmem_* outputs held stable; counter increments each cycle.
  - dmem_ack: next edge goes to DONE and clears dmem_req/we/wstrb. Loads register the formatted data into mem_read_data; stores leave it unchanged.
  - Counter reaches TIMEOUT-1 with no ack: next edge goes to DONE, clears the request, sets mem_read_data=0 and pulses mem_bus_err in the DONE cycle.
  - Ack in the same cycle as the timeout: ack wins, no error.
- DONE: mem_stall=0 for exactly one cycle so MEM/WB captures the result. Always returns to IDLE. Start is not evaluated in DONE; the next instruction is seen in IDLE. dmem_ack in DONE or IDLE is ignored.
- Minimum cost is two stall cycles (IDLE-start, BUSY) when ack arrives in the first BUSY cycle.
- Load formatting uses lane = addr[1:0]:
  - LB/LBU: byte at lane; sign- or zero-extended.
  - LH/LHU: half at addr[1]; sign- or zero-extended.
  - LW: whole word.
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001 << lane.
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011 << (addr[1]*2).
  - SW: wdata = rs2, wstrb = 1111.

Test Plan:
- LW at 0x100, ack 3 cycles after req, rdata=0xDEADBEEF -> dmem_addr=0x100, wstrb=0000, mem_stall high for 4 cycles, DONE cycle shows mem_read_data=0xDEADBEEF with stall=0.
- LB at 0x1001, rdata=0x123480FF -> mem_read_data=0xFFFFFF80; repeat with LBU -> 0x00000080.
- SH at 0x2002, rs2=0x0000ABCD -> dmem_we=1, dmem_addr=0x2000, wdata=0xABCDABCD, wstrb=1100; mem_read_data unchanged.
- LW at 0x3002 -> no dmem_req, mem_misalign pulses 1 cycle, mem_stall never asserted, mem_read_data=0; funct3=011 load behaves identically.
- LW with no ack, TIMEOUT=16 -> dmem_req high 16 cycles then drops, mem_bus_err pulses in DONE, mem_read_data=0. Ack on the 16th cycle instead -> no error, data captured.
- rst asserted mid-BUSY -> dmem_req falls immediately, state IDLE, all outputs 0. Ack arriving one cycle later causes no state change.
